// File: rtl/reg_port_pkg.sv
// Shared constants and helpers for the register-file read-port arbiter.
package reg_port_pkg;

  localparam int NREQ       = 3;
  localparam int SEL_W      = 2;
  localparam int DATA_W_DEF = 16;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_R0 = 2'd0;
  localparam sel_t SEL_R1 = 2'd1;
  localparam sel_t SEL_R2 = 2'd2;

  // Pointer value that gives the requester after idx the highest priority.
  function automatic sel_t ptr_after(input sel_t idx);
    sel_t nxt;
    case (idx)
      SEL_R0:  nxt = SEL_R1;
      SEL_R1:  nxt = SEL_R2;
      default: nxt = SEL_R0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: first eligible requester scanning
// from ptr upward, modulo 3.
module rr_pick3
  import reg_port_pkg::*;
(
  input  logic [NREQ-1:0]  eligible,
  input  logic [SEL_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic [SEL_W-1:0] idx,
  output logic             any_win
);

  sel_t order [NREQ];

  always_comb begin
    case (ptr)
      SEL_R1:  order = '{SEL_R1, SEL_R2, SEL_R0};
      SEL_R2:  order = '{SEL_R2, SEL_R0, SEL_R1};
      default: order = '{SEL_R0, SEL_R1, SEL_R2};
    endcase

    idx     = SEL_R0;
    any_win = 1'b0;
    winner  = '0;
    // Scan lowest priority first so the highest-priority hit is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (eligible[order[k]]) begin
        idx     = order[k];
        any_win = 1'b1;
      end
    end
    if (any_win) winner[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter for a shared register-file read port: grant stage
// drives the address-mux select and read enable, response stage returns data.
module reg_port_arbiter
  import reg_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [SEL_W-1:0]  sel,
  output logic              rf_en,
  input  logic [DATA_W-1:0] rf_data,
  output logic [NREQ-1:0]   valid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  logic [SEL_W-1:0] ptr;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  pick_onehot;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  // A requester still holding REQ in its grant cycle is not re-granted.
  assign eligible = req & ~gnt;

  rr_pick3 u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (pick_onehot),
    .idx      (pick_idx),
    .any_win  (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt   <= '0;
      sel   <= SEL_R0;
      rf_en <= 1'b0;
      ptr   <= SEL_R0;
    end else if (pick_any) begin
      gnt   <= pick_onehot;
      sel   <= pick_idx;
      rf_en <= 1'b1;
      ptr   <= ptr_after(pick_idx);
    end else begin
      gnt   <= '0;
      rf_en <= 1'b0;
    end
  end

  // Read data is valid during the grant cycle and captured at its end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      rdata <= '0;
    end else begin
      valid <= gnt;
      if (rf_en) rdata <= rf_data;
    end
  end

  assign busy = (|gnt) | (|valid);

  a_sel_range: assert property (@(posedge clk) disable iff (!rst_n) sel != 2'd3);
  a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n) ptr != 2'd3);
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_rf_en_gnt: assert property (@(posedge clk) disable iff (!rst_n) rf_en == (|gnt));

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_reg_port_arbiter;
  import reg_port_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [2:0]    req = '0;
  logic [DW-1:0] rf_data = '0;
  logic [2:0]    gnt;
  logic [1:0]    sel;
  logic          rf_en;
  logic [2:0]    valid;
  logic [DW-1:0] rdata;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_port_arbiter #(.DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .rf_en   (rf_en),
    .rf_data (rf_data),
    .valid   (valid),
    .rdata   (rdata),
    .busy    (busy)
  );

  // Behavioural model: requester indices as ints, -1 meaning none.
  int            m_gnt = -1;
  int            m_sel = 0;
  int            m_ptr = 0;
  int            m_val = -1;
  logic [DW-1:0] m_rdata = '0;

  task automatic model_step();
    int w;
    if (!rst_n) begin
      m_gnt = -1; m_sel = 0; m_ptr = 0; m_val = -1; m_rdata = '0;
      return;
    end
    m_val = m_gnt;
    if (m_gnt >= 0) m_rdata = rf_data;
    w = -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (w < 0 && req[i] && i != m_gnt) w = i;
    end
    m_gnt = w;
    if (w >= 0) begin
      m_sel = w;
      m_ptr = (w + 1) % 3;
    end
  endtask

  function automatic logic [2:0] onehot(input int i);
    return (i < 0) ? 3'b000 : 3'(1 << i);
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] eg, input logic [1:0] es,
                         input logic ee, input logic [2:0] ev, input logic [DW-1:0] ed);
    chk({nm, ".gnt"},   32'(gnt),   32'(eg));
    chk({nm, ".sel"},   32'(sel),   32'(es));
    chk({nm, ".rf_en"}, 32'(rf_en), 32'(ee));
    chk({nm, ".valid"}, 32'(valid), 32'(ev));
    chk({nm, ".rdata"}, 32'(rdata), 32'(ed));
    chk({nm, ".busy"},  32'(busy),  32'((|eg) | (|ev)));
  endtask

  typedef struct {
    logic [2:0]    req;
    logic [DW-1:0] rf;
    logic [2:0]    gnt;
    logic [1:0]    sel;
    logic          rf_en;
    logic [2:0]    valid;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] r, logic [DW-1:0] d, logic [2:0] g, logic [1:0] s,
                              logic e, logic [2:0] v, logic [DW-1:0] q);
    vec_t x;
    x.req = r; x.rf = d; x.gnt = g; x.sel = s; x.rf_en = e; x.valid = v; x.rdata = q;
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g_prev, g_cur;
    logic [2:0] exp_order [6];
    logic [2:0] eg, ev;

    // Single request, pointer fairness, stale mask, withdrawn request.
    tbl.push_back(mk(3'b010, 16'h0000, 3'b010, 2'd1, 1'b1, 3'b000, 16'h0000));
    tbl.push_back(mk(3'b000, 16'hBEEF, 3'b000, 2'd1, 1'b0, 3'b010, 16'hBEEF));
    tbl.push_back(mk(3'b011, 16'h1111, 3'b001, 2'd0, 1'b1, 3'b000, 16'hBEEF));
    tbl.push_back(mk(3'b010, 16'h2222, 3'b010, 2'd1, 1'b1, 3'b001, 16'h2222));
    tbl.push_back(mk(3'b000, 16'h3333, 3'b000, 2'd1, 1'b0, 3'b010, 16'h3333));
    tbl.push_back(mk(3'b000, 16'h4444, 3'b000, 2'd1, 1'b0, 3'b000, 16'h3333));
    tbl.push_back(mk(3'b001, 16'h5555, 3'b001, 2'd0, 1'b1, 3'b000, 16'h3333));
    tbl.push_back(mk(3'b001, 16'h6666, 3'b000, 2'd0, 1'b0, 3'b001, 16'h6666));
    tbl.push_back(mk(3'b001, 16'h7777, 3'b001, 2'd0, 1'b1, 3'b000, 16'h6666));
    tbl.push_back(mk(3'b001, 16'h8888, 3'b000, 2'd0, 1'b0, 3'b001, 16'h8888));
    tbl.push_back(mk(3'b000, 16'h9999, 3'b000, 2'd0, 1'b0, 3'b000, 16'h8888));
    tbl.push_back(mk(3'b010, 16'hAAAA, 3'b010, 2'd1, 1'b1, 3'b000, 16'h8888));
    tbl.push_back(mk(3'b000, 16'hBBBB, 3'b000, 2'd1, 1'b0, 3'b010, 16'hBBBB));
    tbl.push_back(mk(3'b100, 16'hCCCC, 3'b100, 2'd2, 1'b1, 3'b000, 16'hBBBB));
    tbl.push_back(mk(3'b000, 16'hDDDD, 3'b000, 2'd2, 1'b0, 3'b100, 16'hDDDD));
    tbl.push_back(mk(3'b101, 16'hEEEE, 3'b001, 2'd0, 1'b1, 3'b000, 16'hDDDD));
    tbl.push_back(mk(3'b000, 16'hFFFF, 3'b000, 2'd0, 1'b0, 3'b001, 16'hFFFF));
    tbl.push_back(mk(3'b000, 16'h0123, 3'b000, 2'd0, 1'b0, 3'b000, 16'hFFFF));

    #1 rst_n = 1'b0;
    #1 chk_all("reset_async", 3'b000, 2'd0, 1'b0, 3'b000, 16'h0000);
    step();
    step();
    chk_all("reset_held", 3'b000, 2'd0, 1'b0, 3'b000, 16'h0000);
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      req = tbl[r].req;
      rf_data = tbl[r].rf;
      step();
      chk_all($sformatf("vec%0d", r), tbl[r].gnt, tbl[r].sel, tbl[r].rf_en,
              tbl[r].valid, tbl[r].rdata);
    end

    // Full contention from reset: each requester drops REQ the cycle after its grant.
    rst_n = 1'b0; req = '0;
    step();
    rst_n = 1'b1;
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    g_prev = '0;
    g_cur = gnt;
    for (int c = 0; c < 6; c++) begin
      req = 3'b111 & ~g_prev;
      rf_data = 16'(c);
      step();
      g_prev = g_cur;
      g_cur = gnt;
      chk($sformatf("contend%0d.gnt", c), 32'(gnt), 32'(exp_order[c]));
      chk($sformatf("contend%0d.sel", c), 32'(sel), 32'(c % 3));
    end
    req = '0;
    step();
    step();

    // Reset mid-flight: grant to 2, reset while its response is due.
    req = 3'b100; rf_data = 16'h5A5A;
    step();
    chk("midrst.gnt", 32'(gnt), 32'(3'b100));
    req = '0;
    step();
    rst_n = 1'b0;
    #1 chk_all("midrst_async", 3'b000, 2'd0, 1'b0, 3'b000, 16'h0000);
    step();
    chk_all("midrst_t2", 3'b000, 2'd0, 1'b0, 3'b000, 16'h0000);
    rst_n = 1'b1;
    step();
    chk_all("midrst_rel", 3'b000, 2'd0, 1'b0, 3'b000, 16'h0000);

    // Pointer returns to 0 on reset; first grant right after release.
    req = 3'b010;
    step();
    chk("ptrrst.pre", 32'(gnt), 32'(3'b010));
    req = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 3'b110;
    step();
    chk("ptrrst.gnt", 32'(gnt), 32'(3'b010));
    chk("ptrrst.sel", 32'(sel), 32'(1));
    req = '0;
    step();
    step();

    // Randomized traffic against the model, with occasional async resets.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < 3; i++) begin
        if (gnt[i])      req[i] = 1'($urandom_range(0, 1));
        else if (req[i]) req[i] = ($urandom_range(0, 15) != 0);
        else             req[i] = 1'($urandom_range(0, 1));
      end
      rf_data = DW'($urandom);
      step();
      eg = onehot(m_gnt);
      ev = onehot(m_val);
      chk("rnd.gnt",   32'(gnt),   32'(eg));
      chk("rnd.sel",   32'(sel),   32'(m_sel));
      chk("rnd.rf_en", 32'(rf_en), 32'(m_gnt >= 0));
      chk("rnd.valid", 32'(valid), 32'(ev));
      chk("rnd.rdata", 32'(rdata), 32'(m_rdata));
      chk("rnd.busy",  32'(busy),  32'((|eg) | (|ev)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
